// File: rtl/multicycle_control_if.sv
// multicycle_control_if: start, instruction-fetch and data-memory
// handshakes plus datapath control strobes of the multi-cycle controller.
interface multicycle_control_if #(
    parameter int IW = 9,
    parameter int CW = 16
);
    logic          Start;
    logic [IW-1:0] Instruction;
    logic          InstrValid;
    logic          MemAck;
    logic          IR_LOAD;
    logic          PC_EN;
    logic          BRANCH;
    logic          MEM_TO_REG;
    logic          MEM_WRITE;
    logic          MEM_READ;
    logic          REG_WRITE;
    logic          IMMEDIATE;
    logic          ZERO_STORE;
    logic          MemReq;
    logic          HALT;
    logic          Error;
    logic          Busy;
    logic [CW-1:0] CycleCount;

    modport master (
        output Start, Instruction, InstrValid, MemAck,
        input  IR_LOAD, PC_EN, BRANCH, MEM_TO_REG, MEM_WRITE,
        input  MEM_READ, REG_WRITE, IMMEDIATE, ZERO_STORE,
        input  MemReq, HALT, Error, Busy, CycleCount
    );

    modport slave (
        input  Start, Instruction, InstrValid, MemAck,
        output IR_LOAD, PC_EN, BRANCH, MEM_TO_REG, MEM_WRITE,
        output MEM_READ, REG_WRITE, IMMEDIATE, ZERO_STORE,
        output MemReq, HALT, Error, Busy, CycleCount
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer with latched IR,
// variable-latency memory handshakes, memory timeout and busy-cycle counter.
module multicycle_control #(
    parameter int IW          = 9,
    parameter int MEM_TIMEOUT = 16,
    parameter int CW          = 16
) (
    input logic                  Clk,
    input logic                  Reset,
    multicycle_control_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED
    } state_t;

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST =
        TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t        state;
    logic [IW-1:0] ir;
    logic [TW-1:0] tcnt;
    logic          err;
    logic [CW-1:0] cyc;

    logic [1:0] op;
    logic       fn;
    logic       is_r, is_br, is_mem, is_lb, is_sb, is_imm, is_halt;
    logic       busy;
    logic       unused_ir;

    assign op      = ir[IW-1:IW-2];
    assign fn      = ir[0];
    assign is_r    = (op == 2'b00);
    assign is_br   = (op == 2'b10);
    assign is_mem  = (op == 2'b01);
    assign is_lb   = is_mem & ~fn;
    assign is_sb   = is_mem & fn;
    assign is_imm  = (op == 2'b11) & ~fn;
    assign is_halt = (op == 2'b11) & fn;
    assign busy    = (state != IDLE) && (state != HALTED);
    assign unused_ir = ^ir[IW-3:1];

    // State sequencing, IR latch, MEM timeout, sticky error, busy counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            ir    <= '0;
            tcnt  <= '0;
            err   <= 1'b0;
            cyc   <= '0;
        end else begin
            if (busy && cyc != {CW{1'b1}})
                cyc <= cyc + 1'b1;
            unique case (state)
                IDLE: begin
                    if (bus.Start) begin
                        state <= FETCH;
                        cyc   <= '0;
                    end
                end
                FETCH: begin
                    if (bus.InstrValid) begin
                        ir    <= bus.Instruction;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    unique case (1'b1)
                        is_halt: state <= HALTED;
                        is_mem: begin
                            state <= MEM;
                            tcnt  <= '0;
                        end
                        default: state <= EXEC;
                    endcase
                end
                EXEC: state <= is_br ? FETCH : WB;
                MEM: begin
                    if (bus.MemAck) begin
                        state <= is_lb ? WB : FETCH;
                    end else if (MEM_TIMEOUT != 0 && tcnt == TLAST) begin
                        err   <= 1'b1;
                        state <= HALTED;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                WB: state <= FETCH;
                HALTED: begin
                    if (bus.Start) begin
                        state <= FETCH;
                        err   <= 1'b0;
                        cyc   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.IR_LOAD    = (state == FETCH) & bus.InstrValid;
    assign bus.BRANCH     = (state == EXEC) & is_br;
    assign bus.PC_EN      = ((state == EXEC) & is_br)
                          | ((state == MEM) & is_sb & bus.MemAck)
                          | (state == WB);
    assign bus.MemReq     = (state == MEM);
    assign bus.MEM_READ   = (state == MEM) & is_lb;
    assign bus.MEM_WRITE  = (state == MEM) & is_sb;
    assign bus.REG_WRITE  = (state == WB);
    assign bus.ZERO_STORE = (state == WB) & ((is_r & ~fn) | is_lb);
    assign bus.MEM_TO_REG = (state == WB) & is_lb;
    assign bus.IMMEDIATE  = (state == WB) & is_imm;
    assign bus.HALT       = (state == HALTED);
    assign bus.Error      = err;
    assign bus.Busy       = busy;
    assign bus.CycleCount = cyc;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: timed random instruction stream with a
// per-instruction scoreboard of strobe counts, latency and CycleCount.
module tb_multicycle_control;
    localparam int IW  = 9;
    localparam int TO  = 4;
    localparam int CW  = 16;
    localparam int CWS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if #(.IW(IW), .CW(CW))  bus ();
    multicycle_control_if #(.IW(IW), .CW(CWS)) bus_s ();

    multicycle_control #(.IW(IW), .MEM_TIMEOUT(TO), .CW(CW)) dut (
        .Clk(clk), .Reset(rst), .bus(bus)
    );
    multicycle_control #(.IW(IW), .MEM_TIMEOUT(TO), .CW(CWS)) dut_s (
        .Clk(clk), .Reset(rst), .bus(bus_s)
    );

    assign bus_s.Start       = bus.Start;
    assign bus_s.Instruction = bus.Instruction;
    assign bus_s.InstrValid  = bus.InstrValid;
    assign bus_s.MemAck      = bus.MemAck;

    typedef struct {
        int span, mreq, mrd, mwr, br, rw, zs, m2r, imm, pce, cc;
        bit err, halt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cum   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] outs();
        return {bus.IR_LOAD, bus.PC_EN, bus.BRANCH, bus.MEM_TO_REG,
                bus.MEM_WRITE, bus.MEM_READ, bus.REG_WRITE,
                bus.IMMEDIATE, bus.ZERO_STORE, bus.MemReq, bus.HALT,
                bus.Error, bus.Busy};
    endfunction

    // Monitor: accumulate strobes from IR_LOAD to completion, then score.
    bit   open = 0, prev_halt = 0, done;
    int   a_span, a_mreq, a_mrd, a_mwr, a_br, a_rw, a_zs, a_m2r, a_imm, a_pce;
    exp_t e;
    always @(negedge clk) begin
        if (rst) begin
            open = 0;
            prev_halt = 0;
        end else begin
            if (bus.IR_LOAD) begin
                open = 1;
                a_span = 0; a_mreq = 0; a_mrd = 0; a_mwr = 0; a_br = 0;
                a_rw = 0; a_zs = 0; a_m2r = 0; a_imm = 0; a_pce = 0;
            end
            if (open) begin
                a_span++;
                a_mreq += int'(bus.MemReq);
                a_mrd  += int'(bus.MEM_READ);
                a_mwr  += int'(bus.MEM_WRITE);
                a_br   += int'(bus.BRANCH);
                a_rw   += int'(bus.REG_WRITE);
                a_zs   += int'(bus.ZERO_STORE);
                a_m2r  += int'(bus.MEM_TO_REG);
                a_imm  += int'(bus.IMMEDIATE);
                a_pce  += int'(bus.PC_EN);
            end
            done = bus.PC_EN || (bus.HALT && !prev_halt);
            if (done) begin
                if (!open || q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_completion: got 1, expected 0 at %0t",
                             $time);
                end else begin
                    e = q.pop_front();
                    chk("latency",     64'(a_span), 64'(e.span));
                    chk("memreq_cyc",  64'(a_mreq), 64'(e.mreq));
                    chk("mem_read",    64'(a_mrd),  64'(e.mrd));
                    chk("mem_write",   64'(a_mwr),  64'(e.mwr));
                    chk("branch",      64'(a_br),   64'(e.br));
                    chk("reg_write",   64'(a_rw),   64'(e.rw));
                    chk("zero_store",  64'(a_zs),   64'(e.zs));
                    chk("mem_to_reg",  64'(a_m2r),  64'(e.m2r));
                    chk("immediate",   64'(a_imm),  64'(e.imm));
                    chk("pc_en",       64'(a_pce),  64'(e.pce));
                    chk("error",       64'(bus.Error), 64'(e.err));
                    chk("halt",        64'(bus.HALT),  64'(e.halt));
                    chk("busy",        64'(bus.Busy),  64'(!e.halt));
                    chk("cyclecount",  64'(bus.CycleCount), 64'(e.cc));
                    chk("cyclecount_sat", 64'(bus_s.CycleCount),
                        64'((e.cc > 7) ? 7 : e.cc));
                    open = 0;
                end
            end
            prev_halt = bus.HALT;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        bus.Start       = 1'($urandom_range(1, 0));
        bus.InstrValid  = 1'($urandom_range(1, 0));
        bus.MemAck      = 1'($urandom_range(1, 0));
        bus.Instruction = IW'($urandom);
    endtask

    // Drive one instruction through its expected schedule; record outcome.
    task automatic run_instr(input logic [IW-1:0] ins, input int f,
                             input int m, output bit halted);
        exp_t x;
        int   span, n;
        logic [1:0] op;
        bit   fn, tmo;
        x = '{default: 0};
        op = ins[IW-1:IW-2];
        fn = ins[0];
        tmo = (op == 2'b01) && (m >= TO);
        span = 0;
        case (op)
            2'b00: begin span = 4; x.rw = 1; x.zs = int'(!fn); x.pce = 1; end
            2'b10: begin span = 3; x.br = 1; x.pce = 1; end
            2'b11: begin
                if (fn) begin span = 3; x.halt = 1; end
                else begin span = 4; x.rw = 1; x.imm = 1; x.pce = 1; end
            end
            default: begin
                if (tmo) begin
                    span = 7; x.mreq = TO; x.err = 1; x.halt = 1;
                    if (fn) x.mwr = TO; else x.mrd = TO;
                end else begin
                    x.mreq = m + 1; x.pce = 1;
                    if (fn) begin span = 3 + m; x.mwr = m + 1; end
                    else begin
                        span = 4 + m; x.mrd = m + 1;
                        x.rw = 1; x.zs = 1; x.m2r = 1;
                    end
                end
            end
        endcase
        x.span = span;
        x.cc = cum + f + span - 1;
        repeat (f) begin noise(); bus.InstrValid = 1'b0; step(); end
        noise();
        bus.InstrValid = 1'b1;
        bus.Instruction = ins;
        q.push_back(x);
        step();
        noise(); step();
        if (op == 2'b01) begin
            n = tmo ? TO : m + 1;
            for (int j = 0; j < n; j++) begin
                noise();
                bus.MemAck = (!tmo && j == m);
                step();
            end
            if (!fn && !tmo) begin noise(); step(); end
        end else if (op == 2'b10) begin
            noise(); step();
        end else if (!(op == 2'b11 && fn)) begin
            noise(); step();
            noise(); step();
        end
        halted = x.halt;
        cum = halted ? 0 : cum + f + span;
    endtask

    task automatic resume(input int h);
        repeat (h) begin noise(); bus.Start = 1'b0; step(); end
        noise(); bus.Start = 1'b1; step();
        cum = 0;
    endtask

    bit            hl;
    logic [IW-1:0] ins;
    initial begin
        bus.Start = 1'b0; bus.InstrValid = 1'b0;
        bus.MemAck = 1'b0; bus.Instruction = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 64'(outs()), 64'd0);
        chk("reset_cyclecount", 64'(bus.CycleCount), 64'd0);
        step();
        repeat (4) begin
            noise(); bus.Start = 1'b0;
            @(negedge clk);
            chk("idle_outputs", 64'(outs()), 64'd0);
            step();
        end
        noise(); bus.Start = 1'b1; step(); cum = 0;

        run_instr(9'b00_101010_0, 0, 0, hl);
        run_instr(9'b01_110011_0, 1, 3, hl);
        run_instr(9'b01_000111_1, 0, 0, hl);
        run_instr(9'b10_010101_1, 2, 0, hl);
        run_instr(9'b11_001100_0, 0, 0, hl);
        run_instr(9'b00_111111_1, 1, 0, hl);
        run_instr(9'b01_010101_0, 0, 4, hl);
        resume(2);
        run_instr(9'b01_010101_0, 0, 3, hl);
        run_instr(9'b01_011101_1, 0, 5, hl);
        resume(0);
        run_instr(9'b11_000000_1, 0, 0, hl);
        resume(3);

        repeat (250) begin
            ins = IW'($urandom);
            ins[IW-1:IW-2] = 2'($urandom_range(3, 0));
            run_instr(ins, $urandom_range(2, 0), $urandom_range(5, 0), hl);
            if (hl) resume($urandom_range(3, 0));
        end

        noise(); bus.InstrValid = 1'b1;
        bus.Instruction = 9'b01_000000_0; step();
        noise(); step();
        noise(); bus.MemAck = 1'b0; step();
        noise(); bus.MemAck = 1'b0; rst = 1'b1; step();
        rst = 1'b0; noise(); bus.Start = 1'b0;
        @(negedge clk);
        chk("midmem_reset_outputs", 64'(outs()), 64'd0);
        chk("midmem_reset_cyclecount", 64'(bus.CycleCount), 64'd0);
        chk("midmem_reset_cc_small", 64'(bus_s.CycleCount), 64'd0);
        step();
        noise(); bus.Start = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", 64'(outs()), 64'd0);
        step();
        noise(); bus.Start = 1'b1; step(); cum = 0;
        run_instr(9'b11_010010_0, 0, 0, hl);

        repeat (3) begin
            bus.InstrValid = 1'b0; bus.Start = 1'b0; bus.MemAck = 1'b0;
            step();
        end
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
